// File: rtl/mreg_queue.sv
`default_nettype none
// ============================================================================
// Module      : mreg_queue
// Description : FWFT multiplicand queue; head is zero-extended to 2*WIDTH bits
//               and can be shifted left in place for shift-add multipliers.
// Revision    : 1.0 - initial release
// ============================================================================
module mreg_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [2*WIDTH-1:0]         data_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic                       shift_en,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [2*WIDTH-1:0] mem_d [DEPTH];
    logic [c_PTR_W-1:0] wr_q, wr_d;
    logic [c_PTR_W-1:0] rd_q, rd_d;
    logic [c_CNT_W-1:0] count_q, count_d;

    logic w_push;
    logic w_pop;
    logic w_shift;

    assign in_ready  = (count_q != c_FULL);
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign data_out  = out_valid ? mem_q[rd_q] : '0;

    assign w_push  = in_valid && in_ready;
    assign w_pop   = out_valid && out_ready;
    assign w_shift = shift_en && out_valid && !out_ready;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (clear) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            // wr != rd whenever push and shift coincide (neither empty nor full)
            if (w_push) begin
                mem_d[wr_q] = {{WIDTH{1'b0}}, data_in};
                wr_d        = wr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                rd_d = rd_q + c_PTR_W'(1);
            end else if (w_shift) begin
                mem_d[rd_q] = mem_q[rd_q] << 1;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + c_CNT_W'(1);
                2'b01:   count_d = count_q - c_CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/mreg_queue.md
# mreg_queue

Parametrised successor to the 8-bit multiplicand register of the shift-add multiplier. Stages up to DEPTH multiplicands in a first-word-fall-through queue with valid/ready on both sides. The head entry is held zero-extended to 2*WIDTH bits and can be shifted left in place, so the multiplier datapath consumes successive partial-product addends directly. Sits between the operand source and the multiplier control/adder.

## Interface

Parameters:
- WIDTH, 8, multiplicand width in bits (≥2)
- DEPTH, 4, queue entries (power of two, ≥2)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- clear  input  1  synchronous flush
- data_in  input  WIDTH  multiplicand to enqueue
- in_valid  input  1  data_in valid
- in_ready  output  1  queue can accept (count < DEPTH)
- data_out  output  2*WIDTH  current head value (zero-extended, possibly shifted)
- out_valid  output  1  queue non-empty
- out_ready  input  1  consumer pops head this cycle
- shift_en  input  1  shift head left by one in place
- count  output  $clog2(DEPTH+1)  entries held

## Operation

- Storage: DEPTH entries of 2*WIDTH bits, write pointer, read pointer (wrap at DEPTH), count register.
- Push: in_valid && in_ready → entry[wr] = {WIDTH'b0, data_in}, wr++ (wraps to 0 after DEPTH-1).
- Pop: out_valid && out_ready → rd++ (wraps), head advances to next entry.
- Shift: shift_en && out_valid && !out_ready → entry[rd] = entry[rd] << 1, zero fill at LSB, MSB discarded (no saturation, no flag).
- Shift with pop in same cycle: pop wins, shift ignored; new head is unshifted.
- shift_en when empty: ignored.
- Pop when empty: ignored; rd and count unchanged.
- Push when full: ignored (in_ready=0); no overwrite.
- Simultaneous push and pop: both take effect, count unchanged. When full, push is still refused (in_ready depends only on count, no combinational path from out_ready).
- Simultaneous push and pop when count=1: new entry becomes head next cycle.
- clear: sets count=0 and wr=rd=0; takes priority over push, pop and shift in that cycle. Entry contents are not cleared.
- in_ready = (count != DEPTH); out_valid = (count != 0); data_out = out_valid ? entry[rd] : 0.

## Timing

- Reset (async): count=0, pointers=0, in_ready=1, out_valid=0, data_out=0. Reset asserted mid-shift-sequence discards all entries.
- Push-to-output latency: 1 cycle. Data accepted at edge N is on data_out with out_valid=1 after edge N when the queue was empty.
- Pop latency: next head is visible immediately after the popping edge.
- Shift: shifted value is visible after the edge where shift_en is sampled; k consecutive shifts yield data << k (mod 2^(2*WIDTH)).
- count updates on the same edge as the push/pop it reflects.
- Outputs in_ready, out_valid and count are functions of registered state only.

## Test plan

- Reset then push 8'hA5 → one cycle later out_valid=1, data_out=16'h00A5, count=1, in_ready=1.
- Push 8'h03, assert shift_en 3 cycles with out_ready=0 → data_out 16'h0006, 16'h000C, 16'h0018. Then pop → out_valid=0, data_out=0.
- Push 8'hFF, shift 9 times → data_out=16'hFE00. Shift 7 more → 16'h0000. No wrap of shifted-out bits.
- Push 8'h11,22,33,44 back-to-back (DEPTH=4) → count=4, in_ready=0. Fifth push 8'h55 ignored. Pop all four → order 11,22,33,44. Pointer wrap: then push 8'h66 → data_out=16'h0066.
- count=2, push 8'h77 with pop and shift_en all in the same cycle → count stays 2, new head unshifted. clear with push same cycle → count=0, out_valid=0, push dropped.
- Assert reset asynchronously mid-cycle with count=3 → out_valid and count drop to 0 before the next clk edge. Deassert, push 8'h01 → data_out=16'h0001.
